// File: rtl/pll_clock_manager.sv
// Post-PLL clock manager: lock qualification, system reset sequencing, and phase-aligned divided enables.
// Optional 50% duty divided clocks are built only when CLKGEN_DUTY50_EN is defined.
module pll_clock_manager #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int DEFAULT_DIV = 1,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              resetn,
  input  logic              pll_locked_in,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ack,
  output logic              ready,
  output logic              sys_resetn,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_div_out,
  output logic [7:0]        lock_lost_count
);
  localparam int QW = $clog2(LOCK_CYCLES);
  localparam logic [QW-1:0] QUAL_LAST = QW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, RUN, LOST} state_t;

  state_t                 state_q, state_d;
  logic [QW-1:0]          qual_q, qual_d;
  logic [7:0]             lost_q, lost_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s, run_q, run_d, ch_ok;
  logic                   ready_q, srst_n_q, ack_q;
  logic [NUM_CH-1:0]      ce_d, ce_q, apply_vec;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked_in};
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    lost_d  = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        qual_d = '0;
        if (lock_s) state_d = QUALIFY;
      end
      QUALIFY: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          qual_d  = '0;
        end else if (qual_q == QUAL_LAST) begin
          state_d = RUN;
          qual_d  = '0;
        end else begin
          qual_d = qual_q + 1'b1;
        end
      end
      RUN: if (!lock_s) state_d = LOST;
      default: begin
        state_d = WAIT_LOCK;
        if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
      end
    endcase
  end

  assign run_q = (state_q == RUN);
  assign run_d = (state_d == RUN);
  assign ch_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

  // Outputs are registered from next-state so they change in the cycle the FSM enters/leaves RUN.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      sync_q   <= '0;
      state_q  <= WAIT_LOCK;
      qual_q   <= '0;
      lost_q   <= '0;
      ready_q  <= 1'b0;
      srst_n_q <= 1'b0;
      ce_q     <= '0;
      ack_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      qual_q   <= qual_d;
      lost_q   <= lost_d;
      ready_q  <= run_d;
      srst_n_q <= run_d;
      ce_q     <= ce_d;
      ack_q    <= |apply_vec;
    end
  end

`ifdef CLKGEN_DUTY50_EN
  logic [NUM_CH-1:0] clk_d, clk_q;
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) clk_q <= '0;
    else         clk_q <= clk_d;
  end
  assign clk_div_out = clk_q;
`else
  assign clk_div_out = '0;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d, pend_q, pend_d;
    logic             pend_v_q, pend_v_d, wr_hit, wrap, apply;

    // A pending divider lands at the wrap so the running period is never cut short.
    always_comb begin
      wr_hit   = cfg_wr && ch_ok && (cfg_ch == CH_W'(gi));
      wrap     = (div_q != '0) && (cnt_q == div_q - DIV_W'(1));
      apply    = pend_v_q && (!run_q || (div_q == '0) || wrap);
      div_d    = apply ? pend_q : div_q;
      pend_d   = wr_hit ? cfg_div : pend_q;
      pend_v_d = wr_hit ? 1'b1 : (apply ? 1'b0 : pend_v_q);
      if (!run_d || !run_q || apply || wrap || (div_q == '0)) cnt_d = '0;
      else                                                     cnt_d = cnt_q + DIV_W'(1);
    end

    assign apply_vec[gi] = apply;
    assign ce_d[gi]      = run_d && (cnt_d == '0) && (div_d != '0);

`ifdef CLKGEN_DUTY50_EN
    logic [DIV_W:0] half;
    assign half      = ({1'b0, div_d} + (DIV_W + 1)'(1)) >> 1;
    assign clk_d[gi] = run_d && (div_d != '0) && ({1'b0, cnt_d} < half);
`endif

    always_ff @(posedge clock_in or negedge resetn) begin
      if (!resetn) begin
        div_q    <= DIV_W'(DEFAULT_DIV);
        cnt_q    <= '0;
        pend_q   <= '0;
        pend_v_q <= 1'b0;
      end else begin
        div_q    <= div_d;
        cnt_q    <= cnt_d;
        pend_q   <= pend_d;
        pend_v_q <= pend_v_d;
      end
    end
  end

  assign cfg_ack         = ack_q;
  assign ready           = ready_q;
  assign sys_resetn      = srst_n_q;
  assign ce_out          = ce_q;
  assign lock_lost_count = lost_q;
endmodule

// File: doc/pll_clock_manager.md
# pll_clock_manager

Post-PLL clock manager that sits directly after the iCE40 PLL wrapper. It qualifies the PLL lock signal, sequences a synchronous system reset, and generates NUM_CH independently programmable, phase-aligned clock-enable channels from the PLL core clock. It also counts lock-loss events so firmware can detect an unstable reference.

## Interface
- NUM_CH, 4: number of divider channels (1..16)
- DIV_W, 16: divider register width
- LOCK_CYCLES, 1024: cycles of continuous lock required before release (≥2)
- SYNC_STAGES, 2: synchroniser depth for pll_locked_in (≥2)
- DEFAULT_DIV, 1: divider value loaded into every channel at reset; 0 = channel disabled
- clock_in  input  1  PLL core clock; all logic on rising edge
- resetn  input  1  asynchronous active-low reset
- pll_locked_in  input  1  raw PLL lock, asynchronous to clock_in
- cfg_wr  input  1  divider write strobe, one cycle
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel
- cfg_div  input  DIV_W  new divider N
- cfg_ack  output  1  one-cycle pulse when a written value takes effect
- ready  output  1  high while in RUN
- sys_resetn  output  1  registered active-low system reset; high only in RUN
- ce_out  output  NUM_CH  per-channel one-cycle enable strobes
- clk_div_out  output  NUM_CH  per-channel divided clock (see Configuration)
- lock_lost_count  output  8  saturating count of RUN→LOST transitions

## Operation
- Reset: all outputs 0; state WAIT_LOCK; every channel divider = DEFAULT_DIV, no pending write; lock_lost_count = 0.
- pll_locked_in passes through a SYNC_STAGES flop chain to produce lock_s.
- WAIT_LOCK: qualification counter cleared; lock_s=1 → QUALIFY.
- QUALIFY: counter increments each cycle; lock_s=0 → WAIT_LOCK (counter cleared); counter = LOCK_CYCLES-1 with lock_s=1 → RUN.
- RUN: sys_resetn=1, ready=1; lock_s=0 → LOST.
- LOST: one cycle; lock_lost_count increments (holds at 255); → WAIT_LOCK.
- Channels: per-channel counter runs 0..N-1 in RUN only; all counters are forced to 0 outside RUN, so all channels are phase-aligned on RUN entry. ce_out[i]=1 when counter=0 and N≠0. N=1 gives ce_out held high throughout RUN; N=0 gives ce_out held 0.
- Config write: cfg_wr with cfg_ch < NUM_CH stores cfg_div in that channel's pending register. It is applied at that channel's wrap (counter = N-1), or on the next cycle if the channel is outside RUN or has N=0. cfg_ack pulses in the cycle after application.
- Second write to the same channel before application: overwrites pending; one ack only.
- Writes to different channels are independent. Simultaneous application on several channels produces a single cfg_ack pulse.
- cfg_ch ≥ NUM_CH: write ignored, no ack.
- After application, the counter restarts from 0 under the new N. No runt strobes.

## Timing
- Lock rise → lock_s: SYNC_STAGES cycles.
- lock_s rise → sys_resetn/ready high: LOCK_CYCLES+1 cycles (registered outputs).
- pll_locked_in fall → sys_resetn low: ≤ SYNC_STAGES+1 cycles. ce_out and clk_div_out go low in the same cycle as sys_resetn.
- ce_out[i] is first high in the same cycle sys_resetn first goes high, then every N cycles.
- resetn assertion mid-operation: all outputs 0 immediately (asynchronous); pending writes are lost.

## Configuration
- CLKGEN_DUTY50_EN defined: clk_div_out[i] is high when counter < ceil(N/2), registered and aligned with ce_out. N=1 gives constant high in RUN; N=0 or outside RUN gives 0.
- CLKGEN_DUTY50_EN undefined: clk_div_out tied to 0 and no duty logic is synthesised. All other behaviour is identical.

## Test plan
- LOCK_CYCLES=16, DEFAULT_DIV=1: assert pll_locked_in at cycle 0 → sys_resetn, ready and ce_out=4'b1111 rise at cycle 19 (SYNC_STAGES=2); all are 0 before that.
- Lock glitch: lock high for 10 cycles, low for 1, then high → release occurs 16+1 cycles after the second synchronised rise; lock_lost_count stays 0.
- In RUN, write ch2 N=4 then ch2 N=6 before ch2 wraps → one cfg_ack; ch2 strobes every 6 cycles, with the first strobe at the wrap +1. Other channels are unaffected.
- Drop lock in RUN → sys_resetn low within 3 cycles, ce_out=0, lock_lost_count=1. Re-lock → channels restart phase-aligned.
- Write cfg_ch=5 with NUM_CH=4 → no cfg_ack and no state change. Write N=0 to ch1 → ack next cycle, ce_out[1] stays 0.
- With CLKGEN_DUTY50_EN and N=5: clk_div_out high 3 cycles, low 2, repeating, rising with ce_out. Without the macro, clk_div_out stays 0 throughout.
